// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Purely declarative: no logic, no latency.
// Backpressure is handled by the modules that import this package.
package ifu_fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK       = ~64'h3;

  // S_REQ: may issue a request; S_WAIT: awaiting a live response;
  // S_DROP: awaiting a response that a flush has already killed.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Instructions are 4-byte aligned; redirect targets are forced onto that grid.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Handshake bundle between fetch, instruction memory and decode.
// Wires only: no latency.
// valid/ready on each of request, response and decode channels.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic            imem_rsp_ready;
  logic [ILEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;

  // Fetch stage side.
  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
           id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  // Memory + decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
           id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/ifu_fetch_pc_gen.sv
// Fetch PC register: +4 on each accepted request, aligned load on redirect.
// New PC is visible the cycle after advance/flush.
// No backpressure of its own; advance is only pulsed on a request transfer.
module ifu_fetch_pc_gen
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc_q
);

  logic [XLEN-1:0] pc_d;

  // Redirect beats increment; increment wraps naturally at 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = align_pc(redirect_pc);
    end else if (advance) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: single-outstanding imem requests, one-entry buffer toward decode.
// Request at N, response at N+k -> id_valid at N+k+1 (at best one instruction per 2 cycles).
// A stalled decode holds the buffer and blocks both new requests and new responses.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipeline_flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            isebreak,
  ifu_fetch_if.master     bus
);

  fetch_state_e    state_q, state_d;
  logic            id_valid_q, id_valid_d;
  logic [ILEN-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            halt_q, halt_d;
  logic [XLEN-1:0] pc_q;

  logic halt_now;
  logic req_valid, rsp_ready;
  logic req_fire, rsp_fire, id_fire;

  // An ebreak sitting in the buffer stops fetch in that very cycle, not one later.
  assign halt_now = halt_q | (isebreak & id_valid_q);

  ifu_fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk        (clk),
    .rst        (rst),
    .flush      (pipeline_flush),
    .redirect_pc(redirect_pc),
    .advance    (req_fire),
    .pc_q       (pc_q)
  );

  // Handshake outputs: request only when the buffer will be free; never during reset.
  always_comb begin
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    case (state_q)
      S_REQ:   req_valid = rst & ~halt_now & (~id_valid_q | bus.id_ready);
      S_WAIT:  rsp_ready = ~id_valid_q | bus.id_ready;
      S_DROP:  rsp_ready = 1'b1;
      default: ;
    endcase
  end

  assign req_fire = req_valid & bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid & rsp_ready;
  assign id_fire  = id_valid_q & bus.id_ready;

  // Next state: normal request/response flow, then flush overrides everything.
  always_comb begin
    state_d    = state_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    req_pc_d   = req_pc_q;
    halt_d     = halt_now;

    if (id_fire) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_fire) begin
          id_inst_d  = bus.imem_rsp_data;
          id_pc_d    = req_pc_q;
          id_valid_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (rsp_fire) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A flush kills the buffer and any response landing this cycle; a request
    // accepted this cycle is still owed a response, which S_DROP swallows.
    if (pipeline_flush) begin
      id_valid_d = 1'b0;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      if (state_q == S_REQ) begin
        state_d = req_fire ? S_DROP : S_REQ;
      end else begin
        state_d = rsp_fire ? S_REQ : S_DROP;
      end
    end
  end

  // State, output buffer and halt registers; halt is cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
      req_pc_q   <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      req_pc_q   <= req_pc_d;
      halt_q     <= halt_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.imem_rsp_ready = rsp_ready;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_inst        = id_inst_q;
  assign bus.id_pc          = id_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory model with programmable latency, decode model,
// scoreboard of expected {pc, inst} filled on response and drained on decode transfer.
// Inputs change at posedge+1, outputs are sampled at posedge+2.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [63:0] redirect;
    int          pre_cycles;
    bit          hold_ready;
    logic [63:0] exp_a0;
    logic [63:0] exp_a1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [63:0] redirect;
  logic        isebreak;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipeline_flush(flush),
    .redirect_pc   (redirect),
    .isebreak      (isebreak),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode model: ebreak is recognised from the presented instruction.
  assign isebreak = (bus.id_inst == EBREAK);

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [63:0] req_log[$];
  logic [63:0] exp_pc, out_addr, mem_addr, ebreak_addr, last_req_addr;
  bit          out_busy, out_stale, mem_busy, halted_m;
  int          mem_cnt, lat, n_req, n_del;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == ebreak_addr) return EBREAK;
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  // One clock: entered at posedge+1 with inputs set, returns at the next posedge+1.
  task automatic cyc();
    bit rf, sf, idf, halt_next;
    exp_t e;
    #1;
    rf  = bus.imem_req_valid & bus.imem_req_ready;
    sf  = bus.imem_rsp_valid & bus.imem_rsp_ready;
    idf = bus.id_valid & bus.id_ready;
    halt_next = halted_m | (bus.id_valid & isebreak);

    if (halted_m) chk("no_req_after_halt", 64'(bus.imem_req_valid), 64'd0);
    chk("id_valid_vs_model", 64'(bus.id_valid), 64'(sbq.size() != 0));

    if (idf && !flush) begin
      n_del++;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_id: got pc %h, expected no instruction", bus.id_pc);
      end else begin
        e = sbq.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_inst", 64'(bus.id_inst), 64'(e.inst));
      end
    end
    if (flush) sbq.delete();

    if (sf) begin
      if (!out_busy) begin
        checks++; errors++;
        $display("FAIL spurious_rsp: got response accepted, expected none outstanding");
      end else if (!out_stale && !flush) begin
        e.pc = out_addr; e.inst = bus.imem_rsp_data;
        sbq.push_back(e);
      end
      out_busy = 1'b0;
    end

    if (rf) begin
      chk("req_addr", bus.imem_req_addr, exp_pc);
      if (out_busy) begin
        checks++; errors++;
        $display("FAIL two_outstanding: got second request %h, expected one outstanding", bus.imem_req_addr);
      end
      out_busy = 1'b1;
      out_addr = bus.imem_req_addr;
      out_stale = flush;
      exp_pc = bus.imem_req_addr + 64'd4;
      n_req++;
      last_req_addr = bus.imem_req_addr;
      req_log.push_back(bus.imem_req_addr);
      mem_addr = bus.imem_req_addr;
    end

    if (flush) begin
      if (out_busy && !rf) out_stale = 1'b1;
      exp_pc = redirect & ~64'h3;
    end

    @(posedge clk);
    #1;
    halted_m = halt_next;
    if (sf) bus.imem_rsp_valid = 1'b0;
    if (rf) begin
      mem_busy = 1'b1;
      mem_cnt = lat;
    end
    if (mem_busy && !bus.imem_rsp_valid) begin
      if (mem_cnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = mem_data(mem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  // Asynchronous reset assertion with immediate output checks, then release.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_rsp_ready", 64'(bus.imem_rsp_ready), 64'd0);
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_inst", 64'(bus.id_inst), 64'h13);
    chk("rst_id_pc", bus.id_pc, 64'd0);
    sbq.delete();
    out_busy = 1'b0; out_stale = 1'b0; mem_busy = 1'b0; halted_m = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    exp_pc = RST_PC;
    repeat (2) cyc();
    chk("rst_req_valid_held", 64'(bus.imem_req_valid), 64'd0);
    rst = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input string name);
    req_log.delete();
    for (int i = 0; i < 40 && req_log.size() < n; i++) cyc();
    if (req_log.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d requests, expected %0d", name, req_log.size(), n);
    end
  endtask

  vec_t        vecs[4];
  logic [63:0] hold_pc;
  logic [31:0] hold_inst;
  int          nr, nd;
  bit          saw_valid;

  initial begin
    vecs[0] = '{64'h8000_0103, 0, 1'b0, 64'h8000_0100, 64'h8000_0104};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[2] = '{64'h0000_0000_0000_1001, 2, 1'b0, 64'h1000, 64'h1004};
    vecs[3] = '{64'h1234_5678_9ABC_DEF7, 3, 1'b1, 64'h1234_5678_9ABC_DEF4, 64'h1234_5678_9ABC_DEF8};

    rst = 1'b0; flush = 1'b0; redirect = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.id_ready = 1'b1;
    lat = 1; ebreak_addr = 64'h1; n_req = 0; n_del = 0; last_req_addr = '0;
    @(posedge clk); #1;
    do_reset();

    // 1: sequential fetch from reset
    wait_reqs(3, "t1");
    if (req_log.size() >= 3) begin
      chk("t1_addr0", req_log[0], 64'h8000_0000);
      chk("t1_addr1", req_log[1], 64'h8000_0004);
      chk("t1_addr2", req_log[2], 64'h8000_0008);
    end
    nd = n_del;
    repeat (4) cyc();
    chk("t1_delivering", 64'(n_del > nd), 64'd1);

    // 2: decode stall holds the buffer and stops fetching
    bus.id_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.id_valid; i++) cyc();
    chk("t2_buffered", 64'(bus.id_valid), 64'd1);
    hold_pc = bus.id_pc; hold_inst = bus.id_inst; nr = n_req;
    for (int i = 0; i < 5; i++) begin
      chk("t2_inst_stable", 64'(bus.id_inst), 64'(hold_inst));
      chk("t2_pc_stable", bus.id_pc, hold_pc);
      chk("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("t2_rsp_ready", 64'(bus.imem_rsp_ready), 64'd0);
      cyc();
    end
    chk("t2_no_req", 64'(n_req), 64'(nr));
    bus.id_ready = 1'b1;
    repeat (6) cyc();

    // 3: flush while waiting; stale response arrives 3 cycles later
    lat = 4; nr = n_req;
    for (int i = 0; i < 20 && n_req == nr; i++) cyc();
    flush = 1'b1; redirect = 64'h8000_0100;
    cyc();
    flush = 1'b0; lat = 1; nr = n_req; saw_valid = 1'b0;
    for (int i = 0; i < 20 && n_req == nr; i++) begin
      if (bus.id_valid) saw_valid = 1'b1;
      cyc();
    end
    chk("t3_id_quiet", 64'(saw_valid), 64'd0);
    chk("t3_next_addr", last_req_addr, 64'h8000_0100);
    repeat (4) cyc();

    // 4: flush coinciding with a response and a ready decode
    nr = n_req;
    for (int i = 0; i < 20 && n_req == nr; i++) cyc();
    chk("t4_rsp_present", 64'(bus.imem_rsp_valid), 64'd1);
    flush = 1'b1; redirect = 64'h8000_0200;
    cyc();
    flush = 1'b0;
    chk("t4_rsp_taken", 64'(out_busy), 64'd0);
    chk("t4_id_valid", 64'(bus.id_valid), 64'd0);
    nr = n_req;
    for (int i = 0; i < 20 && n_req == nr; i++) cyc();
    chk("t4_next_addr", last_req_addr, 64'h8000_0200);
    repeat (3) cyc();

    // Redirect table: alignment, wrap, and retarget of a stalled request
    for (int v = 0; v < 4; v++) begin
      repeat (vecs[v].pre_cycles) cyc();
      if (vecs[v].hold_ready) bus.imem_req_ready = 1'b0;
      flush = 1'b1; redirect = vecs[v].redirect;
      cyc();
      flush = 1'b0;
      if (vecs[v].hold_ready) begin
        repeat (2) cyc();
        bus.imem_req_ready = 1'b1;
      end
      wait_reqs(2, "vec");
      if (req_log.size() >= 2) begin
        chk("vec_addr0", req_log[0], vecs[v].exp_a0);
        chk("vec_addr1", req_log[1], vecs[v].exp_a1);
      end
    end
    repeat (3) cyc();

    // 5: ebreak halts fetch; flush does not resume it
    flush = 1'b1; redirect = 64'h8000_0300;
    cyc();
    flush = 1'b0; ebreak_addr = 64'h8000_0304;
    for (int i = 0; i < 40 && !halted_m; i++) cyc();
    chk("t5_halted", 64'(halted_m), 64'd1);
    nr = n_req;
    repeat (10) cyc();
    chk("t5_no_new_req", 64'(n_req), 64'(nr));
    chk("t5_last_addr", last_req_addr, 64'h8000_0304);
    chk("t5_id_valid", 64'(bus.id_valid), 64'd0);
    flush = 1'b1; redirect = 64'h8000_0400;
    cyc();
    flush = 1'b0;
    repeat (5) cyc();
    chk("t5_halt_survives_flush", 64'(n_req), 64'(nr));

    // 6: reset asserted while waiting for a response
    do_reset();
    ebreak_addr = 64'h1;
    lat = 3; nr = n_req;
    for (int i = 0; i < 20 && n_req == nr; i++) cyc();
    do_reset();
    lat = 1;
    wait_reqs(1, "t6");
    if (req_log.size() >= 1) chk("t6_restart_addr", req_log[0], RST_PC);
    nd = n_del;
    repeat (6) cyc();
    chk("t6_delivering", 64'(n_del > nd), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
